// File: rtl/mont_inv_ctrl.sv
// mont_inv_ctrl
//   Montgomery-domain modular inverter for the Ed448 prime
//   p = 2^448 - 2^224 - 1. Raises the Montgomery-form input xR to the power
//   p-2 with left-to-right square-and-multiply, so the output is x^-1*R mod p.
//   All modular multiplication is delegated to an external mul_mont instance
//   driven over a start/a/b -> result/done handshake; no arithmetic is done here.
//
// Configuration macro:
//   MONT_INV_ZERO_CHK_EN  when defined, a zero operand skips the exponentiation,
//                         returns 0 and raises err together with done.
//                         When undefined, err is tied low and zero simply runs
//                         the full sequence (yielding 0).
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   start       one-cycle request, accepted only while idle and not busy
//   x           operand (Montgomery form), captured when start is accepted
//   result      inverse (Montgomery form), held until the next operation ends
//   done        one-cycle pulse, result/err valid
//   busy        high from the cycle after an accepted start through done
//   err         zero-operand flag, valid with done
//   mul_start   one-cycle request to mul_mont
//   mul_a       multiplier operand A
//   mul_b       multiplier operand B
//   mul_result  multiplier product
//   mul_done    multiplier completion
//
// States:
//   IDLE     | waiting for start
//   SQ_REQ   | issue acc*acc to mul_mont
//   SQ_WAIT  | wait for the square product
//   MUL_REQ  | issue acc*base to mul_mont
//   MUL_WAIT | wait for the multiply product
//   FIN      | latch result, raise done on the next cycle

module mont_inv_ctrl #(
    parameter int                    DATA_WIDTH = 448,
    parameter logic [DATA_WIDTH-1:0] EXP        = {{223{1'b1}}, 1'b0, {222{1'b1}}, 2'b01},
    parameter int                    EXP_MSB    = 447
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  done,
    output logic                  busy,
    output logic                  err,
    output logic                  mul_start,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    input  logic [DATA_WIDTH-1:0] mul_result,
    input  logic                  mul_done
);

    // The top exponent bit is consumed by loading acc = x, so scanning starts one below.
    localparam logic [8:0] IDX_INIT = 9'(EXP_MSB - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SQ_REQ   = 3'd1,
        SQ_WAIT  = 3'd2,
        MUL_REQ  = 3'd3,
        MUL_WAIT = 3'd4,
        FIN      = 3'd5
    } state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] base;
    logic [8:0]            idx;
    logic                  wait_first;
    logic                  accept;
    logic                  op_done;

    assign accept = (state == IDLE) && start && !busy;

    // mul_mont may still present done from the previous product during the
    // first wait cycle, so a completion only counts from the second cycle on.
    assign op_done = ((state == SQ_WAIT) || (state == MUL_WAIT)) && !wait_first && mul_done;

`ifdef MONT_INV_ZERO_CHK_EN
    logic x_zero;
    assign x_zero = (x == '0);
`endif

    // Operands come straight from the registers; acc and base only change on
    // accept or on a consumed completion, so they are stable while waiting.
    assign mul_a = acc;
    assign mul_b = ((state == MUL_REQ) || (state == MUL_WAIT)) ? base : acc;

    always_comb begin
        state_d   = state;
        mul_start = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (EXP_MSB == 0) begin
                        state_d = FIN;
                    end
`ifdef MONT_INV_ZERO_CHK_EN
                    else if (x_zero) begin
                        state_d = FIN;
                    end
`endif
                    else begin
                        state_d = SQ_REQ;
                    end
                end
            end
            SQ_REQ: begin
                mul_start = 1'b1;
                state_d   = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (op_done) begin
                    if (EXP[idx]) begin
                        state_d = MUL_REQ;
                    end else if (idx == 9'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d = SQ_REQ;
                    end
                end
            end
            MUL_REQ: begin
                mul_start = 1'b1;
                state_d   = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (op_done) begin
                    if (idx == 9'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d = SQ_REQ;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            base       <= '0;
            idx        <= IDX_INIT;
            wait_first <= 1'b0;
            result     <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wait_first <= mul_start;
            done       <= (state == FIN);
            // busy covers the FIN cycle and the following done cycle.
            busy       <= (state_d != IDLE) || (state == FIN);

            if (accept) begin
                acc  <= x;
                base <= x;
                idx  <= IDX_INIT;
            end else if (op_done) begin
                acc <= mul_result;
                if (state_d == SQ_REQ) begin
                    idx <= idx - 9'd1;
                end
            end

            if (state == FIN) begin
                result <= acc;
            end
        end
    end

`ifdef MONT_INV_ZERO_CHK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= x_zero;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
